// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
//   SEG_CODES : active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SEG_BLANK : all segments off, including the decimal point
//   AN_OFF    : all anodes off
package seg_pkg;
  localparam logic [6:0] SEG_CODES [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'hF;
endpackage

// File: rtl/hex2seg.sv
// hex2seg: combinational nibble to active-low 7-segment decoder.
//   digit : hex nibble in
//   seg   : {g,f,e,d,c,b,a}, active-low
module hex2seg
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  assign seg = SEG_CODES[digit];
endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 4-digit common-anode seven-segment driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : display enable; blanks output while scanning continues
//   le         : per-digit anode enable
//   dp         : per-digit decimal point (high lights the point)
//   digit      : nibble from the external 4:1 mux, selected by sel
//   sel        : registered digit select driving the external mux
//   an         : registered anode enables, active-low
//   seg        : registered segments {dp,g,f,e,d,c,b,a}, active-low
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV_W = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] le,
  input  logic [3:0] dp,
  input  logic [3:0] digit,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [7:0] seg
);
  logic [DIV_W-1:0] cnt;
  logic             tick;
  logic             lit;
  logic [6:0]       dec;
  assign tick = &cnt;
  assign lit  = en & le[sel];
  hex2seg u_dec (.digit(digit), .seg(dec));
  // The output register samples the current sel together with the digit it
  // selects, so an and seg always describe the same slot, one edge after sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel <= '0;
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      cnt <= cnt + DIV_W'(1);
      sel <= sel + 2'(tick);
      an  <= ~({3'b000, lit} << sel);
      seg <= en ? {~dp[sel], dec} : SEG_BLANK;
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed self-checking bench for seg_scan with DIV_W=2 and a 4:1 nibble mux.
module tb_seg_scan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] le = 4'hF;
  logic [3:0] dp = 4'h0;
  logic [3:0] i0 = 4'h0, i1 = 4'h1, i2 = 4'h2, i3 = 4'h3;
  logic [3:0] digit;
  logic [1:0] sel;
  logic [3:0] an;
  logic [7:0] seg;
  int checks = 0;
  int failures = 0;
  localparam logic [6:0] TAB [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] AN_EXP [0:3] = '{4'hE, 4'hD, 4'hB, 4'h7};
  localparam logic [7:0] SEG_EXP [0:3] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
  localparam logic [7:0] DP_EXP [0:3] = '{8'h92, 8'h08, 8'h92, 8'h88};

  seg_scan #(.DIV_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .le(le), .dp(dp),
    .digit(digit), .sel(sel), .an(an), .seg(seg)
  );

  // External MUX4T1: combinational function of sel.
  assign digit = sel == 2'd0 ? i0 : sel == 2'd1 ? i1 : sel == 2'd2 ? i2 : i3;

  always #5 clk = ~clk;

  // Leaves the bench at a negedge with reset just released (cycle n=0).
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({sel, an, seg} !== {2'd0, 4'hF, 8'hFF}) begin
        failures++;
        $display("FAIL reset_hold k=%0d got sel=%h an=%h seg=%h exp sel=0 an=F seg=FF", k, sel, an, seg);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel, an, seg} !== {2'd0, 4'hE, 8'hC0}) begin
      failures++;
      $display("FAIL reset_release got sel=%h an=%h seg=%h exp sel=0 an=E seg=C0", sel, an, seg);
    end
  endtask

  task automatic test_scan();
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      int s, p;
      @(negedge clk);
      s = (n / 4) % 4;
      p = ((n - 1) / 4) % 4;
      checks++;
      if ({sel, an, seg} !== {2'(s), AN_EXP[p], SEG_EXP[p]}) begin
        failures++;
        $display("FAIL scan n=%0d got sel=%h an=%h seg=%h exp sel=%h an=%h seg=%h",
                 n, sel, an, seg, 2'(s), AN_EXP[p], SEG_EXP[p]);
      end
    end
  endtask

  task automatic test_decode();
    for (int v = 0; v < 16; v++) begin
      do_reset();
      i0 = 4'(v);
      @(negedge clk);
      checks++;
      if ({sel, an, seg} !== {2'd0, 4'hE, 1'b1, TAB[v]}) begin
        failures++;
        $display("FAIL decode v=%h got sel=%h an=%h seg=%h exp seg=%h", v, sel, an, seg, {1'b1, TAB[v]});
      end
    end
    do_reset();
    i0 = 4'h3;
    @(negedge clk);
    i0 = 4'h5;
    checks++;
    if (seg !== 8'hB0) begin
      failures++;
      $display("FAIL digit_change_before got seg=%h exp seg=B0", seg);
    end
    @(negedge clk);
    checks++;
    if ({sel, seg} !== {2'd0, 8'h92}) begin
      failures++;
      $display("FAIL digit_change_after got sel=%h seg=%h exp sel=0 seg=92", sel, seg);
    end
    i0 = 4'h0;
  endtask

  task automatic test_enables();
    logic [3:0] ea;
    le = 4'b1011;
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      int p;
      @(negedge clk);
      p = ((n - 1) / 4) % 4;
      ea = le[p] ? AN_EXP[p] : 4'hF;
      checks++;
      if ({an, seg} !== {ea, SEG_EXP[p]}) begin
        failures++;
        $display("FAIL le_mask n=%0d got an=%h seg=%h exp an=%h seg=%h", n, an, seg, ea, SEG_EXP[p]);
      end
    end
    le = 4'hF;
    do_reset();
    repeat (3) @(negedge clk);
    // cnt is at all-ones here, so en falls in the same cycle as a tick.
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({sel, an, seg} !== {2'd1, 4'hF, 8'hFF}) begin
      failures++;
      $display("FAIL en_off_tick got sel=%h an=%h seg=%h exp sel=1 an=F seg=FF", sel, an, seg);
    end
    @(negedge clk);
    checks++;
    if ({sel, an, seg} !== {2'd1, 4'hF, 8'hFF}) begin
      failures++;
      $display("FAIL en_off_hold got sel=%h an=%h seg=%h exp sel=1 an=F seg=FF", sel, an, seg);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel, an, seg} !== {2'd1, 4'hD, 8'hF9}) begin
      failures++;
      $display("FAIL en_resume got sel=%h an=%h seg=%h exp sel=1 an=D seg=F9", sel, an, seg);
    end
  endtask

  task automatic test_dp();
    dp = 4'b0010;
    {i0, i1, i2, i3} = {4'h5, 4'hA, 4'h5, 4'hA};
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      int p;
      @(negedge clk);
      p = ((n - 1) / 4) % 4;
      checks++;
      if ({an, seg} !== {AN_EXP[p], DP_EXP[p]}) begin
        failures++;
        $display("FAIL dp n=%0d got an=%h seg=%h exp an=%h seg=%h", n, an, seg, AN_EXP[p], DP_EXP[p]);
      end
    end
    dp = 4'h0;
    {i0, i1, i2, i3} = {4'h0, 4'h1, 4'h2, 4'h3};
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (9) @(negedge clk);
    checks++;
    if ({sel, an} !== {2'd2, 4'hB}) begin
      failures++;
      $display("FAIL mid_pre got sel=%h an=%h exp sel=2 an=B", sel, an);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, an, seg} !== {2'd0, 4'hF, 8'hFF}) begin
      failures++;
      $display("FAIL mid_async got sel=%h an=%h seg=%h exp sel=0 an=F seg=FF", sel, an, seg);
    end
    @(negedge clk);
    checks++;
    if ({sel, an, seg} !== {2'd0, 4'hF, 8'hFF}) begin
      failures++;
      $display("FAIL mid_held got sel=%h an=%h seg=%h exp sel=0 an=F seg=FF", sel, an, seg);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      logic [1:0] es;
      @(negedge clk);
      es = n < 4 ? 2'd0 : 2'd1;
      checks++;
      if (sel !== es) begin
        failures++;
        $display("FAIL mid_restart n=%0d got sel=%h exp sel=%h", n, sel, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_enables();
    test_dp();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
